// File: rtl/axil_gpio_pkg.sv
// axil_gpio_pkg: register offsets, response codes and FSM states
// shared by the AXI-Lite GPIO bank.
package axil_gpio_pkg;

  localparam logic [3:0] OFS_OUT = 4'h0;
  localparam logic [3:0] OFS_DIR = 4'h4;
  localparam logic [3:0] OFS_IN  = 4'h8;
  localparam logic [3:0] OFS_IRQ = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Expand byte strobes to a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/axil_gpio_bank_sync.sv
// gpio_sync: 2-flop input synchroniser; with GPIO_IRQ_EN defined it
// also keeps the previous synced value and flags any edge.
module gpio_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
`ifdef GPIO_IRQ_EN
  output logic [W-1:0] edge_o,
`endif
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

`ifdef GPIO_IRQ_EN
  logic [W-1:0] prev_q, prev_d;

  always_comb prev_d = s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  assign edge_o = s2_q ^ prev_q;
`endif

endmodule

// File: rtl/axil_gpio_bank.sv
// axil_gpio_bank: AXI4-Lite slave with NUM_CH GPIO channels (OUT/DIR/IN).
// Define GPIO_IRQ_EN to add per-channel edge IRQ_STAT (W1C) and irq.
module axil_gpio_bank
  import axil_gpio_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_CH     = 4,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [31:0]                  S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [31:0]                  S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_o,
  output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_oe,
  input  logic [NUM_CH*GPIO_WIDTH-1:0] gpio_i,
  output logic                         irq
);

  localparam int GW = GPIO_WIDTH;

  typedef logic [GW-1:0] word_t;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic awready_q, awready_d;
  logic wready_q, wready_d;
  logic bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic aw_got_q, aw_got_d;
  logic w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;

  logic arready_q, arready_d;
  logic rvalid_q, rvalid_d;
  logic [1:0] rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  word_t out_q [NUM_CH];
  word_t out_d [NUM_CH];
  word_t dir_q [NUM_CH];
  word_t dir_d [NUM_CH];
  word_t in_s  [NUM_CH];

  logic aw_hs, w_hs;
  logic [31:0] wmask;

`ifdef GPIO_IRQ_EN
  word_t stat_q   [NUM_CH];
  word_t stat_d   [NUM_CH];
  word_t stat_clr [NUM_CH];
  word_t edge_s   [NUM_CH];
  logic irq_q, irq_d;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gpio_sync #(.W(GW)) u_sync (
      .clk    (S_AXI_ACLK),
      .rst    (S_AXI_ARESET),
      .d_i    (gpio_i[c*GW +: GW]),
`ifdef GPIO_IRQ_EN
      .edge_o (edge_s[c]),
`endif
      .q_o    (in_s[c])
    );
    assign gpio_o[c*GW +: GW]  = out_q[c];
    assign gpio_oe[c*GW +: GW] = dir_q[c];
  end

  function automatic word_t merge(
    input word_t       old,
    input logic [31:0] d,
    input logic [31:0] m
  );
    return (old & ~m[GW-1:0]) | (d[GW-1:0] & m[GW-1:0]);
  endfunction

  // Write path: AW and W latch independently, commit once both are held.
  always_comb begin
    w_state_d = w_state_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    out_d     = out_q;
    dir_d     = dir_q;
`ifdef GPIO_IRQ_EN
    for (int c = 0; c < NUM_CH; c++) stat_clr[c] = '0;
`endif
    aw_hs = S_AXI_AWVALID & awready_q;
    w_hs  = S_AXI_WVALID & wready_q;
    if (aw_hs) begin
      aw_got_d = 1'b1;
      awaddr_d = S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_got_d = 1'b1;
      wdata_d = S_AXI_WDATA;
      wstrb_d = S_AXI_WSTRB;
    end
    wmask = strb_mask(wstrb_d);
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_got_d && w_got_d) begin
          bresp_d = RESP_SLVERR;
          for (int c = 0; c < NUM_CH; c++) begin
            if (int'(awaddr_d[ADDR_WIDTH-1:4]) == c) begin
              bresp_d = RESP_OKAY;
              unique case (awaddr_d[3:2])
                OFS_OUT[3:2]: out_d[c] = merge(out_q[c], wdata_d, wmask);
                OFS_DIR[3:2]: dir_d[c] = merge(dir_q[c], wdata_d, wmask);
                OFS_IN[3:2]:  ;
`ifdef GPIO_IRQ_EN
                OFS_IRQ[3:2]: stat_clr[c] = wdata_d[GW-1:0] & wmask[GW-1:0];
`else
                OFS_IRQ[3:2]: ;
`endif
              endcase
            end
          end
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_state_d == W_IDLE) && !w_got_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          for (int c = 0; c < NUM_CH; c++) begin
            if (int'(S_AXI_ARADDR[ADDR_WIDTH-1:4]) == c) begin
              rresp_d = RESP_OKAY;
              unique case (S_AXI_ARADDR[3:2])
                OFS_OUT[3:2]: rdata_d = 32'(out_q[c]);
                OFS_DIR[3:2]: rdata_d = 32'(dir_q[c]);
                OFS_IN[3:2]:  rdata_d = 32'(in_s[c]);
`ifdef GPIO_IRQ_EN
                OFS_IRQ[3:2]: rdata_d = 32'(stat_q[c]);
`else
                OFS_IRQ[3:2]: rdata_d = '0;
`endif
              endcase
            end
          end
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

`ifdef GPIO_IRQ_EN
  // A fresh edge outranks a same-cycle clear.
  always_comb begin
    irq_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      stat_d[c] = (stat_q[c] & ~stat_clr[c]) | edge_s[c];
      irq_d     = irq_d | (|stat_d[c]);
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      stat_q <= '{default: '0};
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      out_q     <= '{default: '0};
      dir_q     <= '{default: '0};
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  logic unused_addr;
  assign unused_addr = ^{awaddr_q[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axil_gpio_bank.sv
// tb_axil_gpio_bank: randomized AXI-Lite traffic against a register-level
// model of the GPIO bank, plus directed literal checks.
module tb_axil_gpio_bank;

  localparam int AW  = 7;
  localparam int NCH = 4;
  localparam int GW  = 32;
  localparam int NW  = NCH * GW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NW-1:0] gpio_o, gpio_oe, gpio_i;
  logic irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [GW-1:0] m_out [NCH];
  logic [GW-1:0] m_dir [NCH];
  logic [NW-1:0] m_in;
  bit model_on = 0;

  axil_gpio_bank #(.ADDR_WIDTH(AW), .NUM_CH(NCH), .GPIO_WIDTH(GW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .gpio_o        (gpio_o),
    .gpio_oe       (gpio_oe),
    .gpio_i        (gpio_i),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] flat(input bit dir);
    logic [NW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*GW +: GW] = dir ? m_dir[c] : m_out[c];
    return v;
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] a,
                                             input logic [31:0] d,
                                             input logic [3:0] s);
    int ch;
    int off;
    ch  = int'(a) / 16;
    off = (int'(a) % 16) / 4;
    if (ch >= NCH) return 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) begin
        if (off == 0) m_out[ch][k*8 +: 8] = d[k*8 +: 8];
        if (off == 1) m_dir[ch][k*8 +: 8] = d[k*8 +: 8];
      end
    end
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a,
                                             output logic [1:0] resp,
                                             output bit known);
    int ch;
    int off;
    ch    = int'(a) / 16;
    off   = (int'(a) % 16) / 4;
    known = 1;
    resp  = 2'b00;
    if (ch >= NCH) begin
      resp = 2'b10;
      return 32'h0;
    end
    if (off == 0) return m_out[ch];
    if (off == 1) return m_dir[ch];
    if (off == 2) return m_in[ch*GW +: GW];
`ifdef GPIO_IRQ_EN
    known = 0;
`endif
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("gpio_o", gpio_o, flat(0));
      chk("gpio_oe", gpio_oe, flat(1));
`ifndef GPIO_IRQ_EN
      chk("irq_off", irq, 1'b0);
`endif
    end
  end

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, comm = 0, b_done = 0;
    bit aw_hs, w_hs, b_hs;
    int cyc = 0, bcnt = 0;
    logic [1:0] exp_r = 2'b00;
    resp = 2'bxx;
    while (!b_done && cyc < 100) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      bready  = comm && bcnt >= b_dly;
      @(negedge clk);
      chk("awready", awready, !aw_done);
      chk("wready", wready, !w_done);
      chk("bvalid", bvalid, comm);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (bvalid) begin
        chk("bresp", bresp, exp_r);
        resp = bresp;
        bcnt++;
      end
      @(posedge clk);
      #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      if (aw_done && w_done && !comm) begin
        comm  = 1;
        exp_r = model_write(a, d, s);
      end
      b_done = b_hs;
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    bready  = 0;
    if (!b_done) chk("write_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int ar_dly,
                          input int r_dly, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, first = 1, known = 1;
    bit ar_hs, r_hs;
    int cyc = 0, rcnt = 0;
    logic [31:0] exp_d = 32'h0;
    logic [1:0] exp_r = 2'b00;
    logic [31:0] held = 32'hx;
    logic [1:0] heldr = 2'bxx;
    while (!r_done && cyc < 100) begin
      araddr  = a;
      arvalid = !ar_done && cyc >= ar_dly;
      rready  = ar_done && rcnt >= r_dly;
      @(negedge clk);
      chk("arready", arready, !ar_done);
      chk("rvalid", rvalid, ar_done);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (ar_hs) exp_d = model_read(a, exp_r, known);
      if (rvalid) begin
        if (first) begin
          first = 0;
          held  = rdata;
          heldr = rresp;
          if (known) chk("rdata", rdata, exp_d);
          chk("rresp", rresp, exp_r);
        end else begin
          chk("rdata_stable", rdata, held);
          chk("rresp_stable", rresp, heldr);
        end
        rcnt++;
      end
      @(posedge clk);
      #1;
      ar_done = ar_done | ar_hs;
      r_done  = r_hs;
      cyc++;
    end
    arvalid = 0;
    rready  = 0;
    if (!r_done) chk("read_timeout", 0, 1);
    data = held;
    resp = heldr;
  endtask

  task automatic set_gpio_i(input logic [NW-1:0] v);
    gpio_i = v;
    repeat (3) @(posedge clk);
    #1;
    m_in = v;
  endtask

  logic [1:0] r;
  logic [31:0] d;
  int op;
  logic [AW-1:0] ra;

  initial begin
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0; gpio_i = '0;
    m_in = '0;
    for (int c = 0; c < NCH; c++) begin
      m_out[c] = '0;
      m_dir[c] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_gpio_o", gpio_o, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("awready_pre", awready, 0);
    @(posedge clk);
    #1;
    chk("awready_rise", awready, 1);
    chk("wready_rise", wready, 1);
    chk("arready_rise", arready, 1);
    model_on = 1;

    axi_write(7'h00, 32'hCAFE1234, 4'hF, 0, 0, 0, r);
    chk("t1_bresp", r, 2'b00);
    axi_write(7'h04, 32'hFFFF0000, 4'hF, 0, 0, 0, r);
    chk("t1_gpio_o", gpio_o[31:0], 32'hCAFE1234);
    chk("t1_gpio_oe", gpio_oe[31:0], 32'hFFFF0000);
    axi_read(7'h00, 0, 0, d, r);
    chk("t1_rd_out", d, 32'hCAFE1234);
    axi_read(7'h04, 0, 0, d, r);
    chk("t1_rd_dir", d, 32'hFFFF0000);

    axi_write(7'h10, 32'hFACEB00D, 4'b0001, 0, 0, 0, r);
    axi_read(7'h10, 0, 0, d, r);
    chk("t2_strb1", d, 32'h0000000D);
    axi_write(7'h10, 32'hFACEB00D, 4'b0100, 0, 0, 0, r);
    axi_read(7'h10, 0, 0, d, r);
    chk("t2_strb4", d, 32'h00CE000D);

    axi_write(7'h20, 32'h11223344, 4'hF, 0, 3, 4, r);
    chk("t3_commit", gpio_o[95:64], 32'h11223344);
    axi_write(7'h21, 32'h55667788, 4'hF, 2, 0, 1, r);
    chk("t3_wfirst", gpio_o[95:64], 32'h55667788);

    axi_write(7'h40, 32'h12345678, 4'hF, 0, 0, 0, r);
    chk("t4_bresp", r, 2'b10);
    axi_read(7'h44, 0, 0, d, r);
    chk("t4_rdata", d, 32'h0);
    chk("t4_rresp", r, 2'b10);

    gpio_i[39:32] = 8'hA5;
    @(posedge clk);
    #1;
    axi_read(7'h18, 0, 0, d, r);
    chk("t5_old", d, 32'h0);
    m_in = gpio_i;
    axi_read(7'h18, 0, 5, d, r);
    chk("t5_new", d, 32'h000000A5);

`ifdef GPIO_IRQ_EN
    for (int c = 0; c < NCH; c++)
      axi_write(AW'(c * 16 + 12), 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    chk("t6_irq_clear", irq, 0);
    set_gpio_i(gpio_i ^ NW'(1));
    chk("t6_irq_set", irq, 1);
    axi_read(7'h0C, 0, 0, d, r);
    chk("t6_stat", d, 32'h1);
    axi_write(7'h0C, 32'h1, 4'hF, 0, 0, 0, r);
    chk("t6_irq_w1c", irq, 0);
`else
    axi_read(7'h0C, 0, 0, d, r);
    chk("t6_rd_c", d, 32'h0);
    chk("t6_rresp_c", r, 2'b00);
    axi_write(7'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    chk("t6_bresp_c", r, 2'b00);
    set_gpio_i(gpio_i ^ NW'(1));
    chk("t6_irq_off", irq, 0);
`endif

    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 9));
      ra = AW'($urandom_range(0, 79));
      if (op < 4)
        axi_write(ra, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), r);
      else if (op < 9)
        axi_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 d, r);
      else
        set_gpio_i({$urandom, $urandom, $urandom, $urandom});
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
